// File: rtl/riscv_fetch_pkg.sv
// Shared types for the riscv_cpu instruction-fetch stage: FSM states, the
// {pc, instr} entry buffered between IF and ID, and a word-align helper.
package riscv_fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_fetch_if.sv
// IF-stage bus: instruction-memory req/rvalid handshake, EX/WB redirect and
// the valid/ready hand-off to ID. master = fetch stage, slave = environment.
interface riscv_fetch_if;
  import riscv_fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// IF/ID buffer: power-of-2 deep FIFO of fetch_entry_t with push/pop/flush.
// Registered: a pushed entry becomes visible at head_o the following cycle.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 2,
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     data_i,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: storage is reset as well so id_pc/id_instr read zero out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // The fetch FSM only issues when a slot is guaranteed, so a full push is a bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (push_i && !flush_i) |-> (count_q < CNT_W'(FIFO_DEPTH) || pop_i));

endmodule

// File: rtl/riscv_fetch_stage.sv
// IF stage: owns the PC, issues one-at-a-time word fetches, buffers responses
// for ID and handles redirects. `define RISCV_FETCH_PERF_EN adds perf counters.
module riscv_fetch_stage
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  riscv_fetch_if.master      bus
`ifdef RISCV_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t     state_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  inflight_pc_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             id_valid;
  logic             push;
  logic             pop;
  logic             space;
  logic             issue;

  assign id_valid   = (count != '0);
  assign pop        = id_valid && bus.id_ready && !bus.redirect_valid;
  assign push       = (state_q == WAIT) && bus.imem_rvalid && !bus.redirect_valid;
  assign push_entry = '{pc: inflight_pc_q, instr: bus.imem_rdata};

  // Space looks at the occupancy after this cycle, so a same-cycle pop frees a slot.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    space      = (count_next < CNT_W'(FIFO_DEPTH));
    issue      = 1'b0;
    if (!bus.redirect_valid) begin
      unique case (state_q)
        FETCH:   issue = space;
        WAIT:    issue = bus.imem_rvalid && space;
        default: issue = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
    end else begin
      if (bus.redirect_valid) begin
        pc_q <= word_align(bus.redirect_pc);
      end else if (issue) begin
        pc_q          <= pc_q + XLEN'(4);
        inflight_pc_q <= pc_q;
      end
      unique case (state_q)
        IDLE:  state_q <= FETCH;
        FETCH: if (issue) state_q <= WAIT;
        WAIT: begin
          // A redirect with no response yet leaves a stale word in flight.
          if (bus.redirect_valid)   state_q <= bus.imem_rvalid ? FETCH : DRAIN;
          else if (bus.imem_rvalid) state_q <= issue ? WAIT : FETCH;
        end
        DRAIN: if (bus.imem_rvalid) state_q <= FETCH;
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .data_i  (push_entry),
    .count_o (count),
    .head_o  (head)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = id_valid;
  assign bus.id_instr  = head.instr;
  assign bus.id_pc     = head.pc;

`ifdef RISCV_FETCH_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (id_valid && !bus.id_ready && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.redirect_valid && flush_cnt_q != '1)        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
